match_control: RTL

Parametrised match controller that sequences a multi-round duel between the player and the enemy. It tracks hit points and rounds won for each side, applies post-hit invulnerability frames, and supports pause/abort. It generates the round-start and enemy-AI tick pulses consumed by the movement and bullet blocks. It sits between those blocks (hit/shield sources) and the renderer (state/HP/round outputs).

---
 rtl/match_control_if.sv | 34 +++
 rtl/match_control.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/match_control_if.sv
// match_control_if: button/hit inputs and renderer-facing status of the match controller
interface match_control_if #(
    parameter int HP_W = 2,
    parameter int RW   = 2
);
    logic            select;
    logic            pause;
    logic            player_hit;
    logic            enemy_hit;
    logic            player_shield;
    logic            enemy_shield;
    logic [2:0]      o_state;
    logic            o_is_gaming;
    logic [HP_W-1:0] o_player_hp;
    logic [HP_W-1:0] o_enemy_hp;
    logic [RW-1:0]   o_player_rounds;
    logic [RW-1:0]   o_enemy_rounds;
    logic            o_player_invuln;
    logic            o_enemy_invuln;
    logic            o_round_start;
    logic            o_ai_tick;

    modport master (
        output select, pause, player_hit, enemy_hit, player_shield, enemy_shield,
        input  o_state, o_is_gaming, o_player_hp, o_enemy_hp, o_player_rounds,
               o_enemy_rounds, o_player_invuln, o_enemy_invuln, o_round_start, o_ai_tick
    );

    modport slave (
        input  select, pause, player_hit, enemy_hit, player_shield, enemy_shield,
        output o_state, o_is_gaming, o_player_hp, o_enemy_hp, o_player_rounds,
               o_enemy_rounds, o_player_invuln, o_enemy_invuln, o_round_start, o_ai_tick
    );
endinterface

// File: rtl/match_control.sv
// match_control: multi-round duel sequencer tracking HP, rounds, i-frames, pause and AI tick
module match_control #(
    parameter int HP_MAX        = 3,
    parameter int HP_W          = 2,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int RW            = 2,
    parameter int IFRAMES       = 32,
    parameter int ROUND_PAUSE   = 64,
    parameter int AI_TICK       = 128
) (
    input logic            clk,
    input logic            rst,
    match_control_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        PAUSE     = 3'd2,
        ROUND_END = 3'd3,
        WIN       = 3'd4,
        LOSE      = 3'd5
    } state_t;

    localparam int IW = $clog2(IFRAMES + 1);
    localparam int AW = $clog2(AI_TICK);
    localparam int PW = $clog2(ROUND_PAUSE + 1);
    localparam logic [HP_W-1:0] HP_FULL = HP_W'(HP_MAX);
    localparam logic [IW-1:0]   IF_LOAD = IW'(IFRAMES);
    localparam logic [AW-1:0]   AI_LAST = AW'(AI_TICK - 1);
    localparam logic [PW-1:0]   RP_LAST = PW'(ROUND_PAUSE - 1);
    localparam logic [RW-1:0]   WIN_CNT = RW'(ROUNDS_TO_WIN);

    state_t          state_q, state_d;
    logic [HP_W-1:0] php_q, php_d, ehp_q, ehp_d;
    logic [RW-1:0]   prnd_q, prnd_d, ernd_q, ernd_d;
    logic [IW-1:0]   pinv_q, pinv_d, einv_q, einv_d;
    logic [AW-1:0]   ai_q, ai_d;
    logic [PW-1:0]   rend_q, rend_d;
    logic            sel_prev_q, pau_prev_q;
    logic            rs_q, rs_d, tick_q, tick_d;
    logic            sel_e, pau_e, p_dmg, e_dmg, reload, clear_rounds;

    assign sel_e = bus.select && !sel_prev_q;
    assign pau_e = bus.pause && !pau_prev_q;
    assign p_dmg = bus.player_hit && !bus.player_shield && pinv_q == '0 && php_q != '0;
    assign e_dmg = bus.enemy_hit && !bus.enemy_shield && einv_q == '0 && ehp_q != '0;

    // Register bank; edge history resets high so a button held through reset is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            php_q      <= HP_FULL;
            ehp_q      <= HP_FULL;
            prnd_q     <= '0;
            ernd_q     <= '0;
            pinv_q     <= '0;
            einv_q     <= '0;
            ai_q       <= '0;
            rend_q     <= '0;
            sel_prev_q <= 1'b1;
            pau_prev_q <= 1'b1;
            rs_q       <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            php_q      <= php_d;
            ehp_q      <= ehp_d;
            prnd_q     <= prnd_d;
            ernd_q     <= ernd_d;
            pinv_q     <= pinv_d;
            einv_q     <= einv_d;
            ai_q       <= ai_d;
            rend_q     <= rend_d;
            sel_prev_q <= bus.select;
            pau_prev_q <= bus.pause;
            rs_q       <= rs_d;
            tick_q     <= tick_d;
        end
    end

    // Next-state, damage, round scoring and pulse generation
    always_comb begin
        state_d      = state_q;
        php_d        = php_q;
        ehp_d        = ehp_q;
        prnd_d       = prnd_q;
        ernd_d       = ernd_q;
        pinv_d       = pinv_q;
        einv_d       = einv_q;
        ai_d         = '0;
        rend_d       = '0;
        rs_d         = 1'b0;
        tick_d       = 1'b0;
        reload       = 1'b0;
        clear_rounds = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_e) begin
                    state_d      = PLAY;
                    reload       = 1'b1;
                    clear_rounds = 1'b1;
                    rs_d         = 1'b1;
                end
            end
            PLAY: begin
                tick_d = ai_q == AI_LAST;
                ai_d   = ai_q == AI_LAST ? '0 : ai_q + 1'b1;
                php_d  = p_dmg ? php_q - 1'b1 : php_q;
                ehp_d  = e_dmg ? ehp_q - 1'b1 : ehp_q;
                pinv_d = p_dmg ? IF_LOAD : (pinv_q != '0 ? pinv_q - 1'b1 : pinv_q);
                einv_d = e_dmg ? IF_LOAD : (einv_q != '0 ? einv_q - 1'b1 : einv_q);
                if (php_q == '0 || ehp_q == '0) begin
                    state_d = ROUND_END;
                    prnd_d  = (ehp_q == '0 && php_q != '0) ? prnd_q + 1'b1 : prnd_q;
                    ernd_d  = (php_q == '0 && ehp_q != '0) ? ernd_q + 1'b1 : ernd_q;
                end else if (pau_e) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                ai_d = ai_q;
                if (pau_e) begin
                    state_d = PLAY;
                end else if (sel_e) begin
                    state_d      = IDLE;
                    reload       = 1'b1;
                    clear_rounds = 1'b1;
                end
            end
            ROUND_END: begin
                rend_d = rend_q + 1'b1;
                if (rend_q == RP_LAST) begin
                    rend_d = '0;
                    if (prnd_q == WIN_CNT) begin
                        state_d = WIN;
                    end else if (ernd_q == WIN_CNT) begin
                        state_d = LOSE;
                    end else begin
                        state_d = PLAY;
                        reload  = 1'b1;
                        rs_d    = 1'b1;
                    end
                end
            end
            WIN, LOSE: begin
                if (sel_e) begin
                    state_d      = IDLE;
                    reload       = 1'b1;
                    clear_rounds = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reload) begin
            php_d  = HP_FULL;
            ehp_d  = HP_FULL;
            pinv_d = '0;
            einv_d = '0;
        end
        if (clear_rounds) begin
            prnd_d = '0;
            ernd_d = '0;
        end
    end

    assign bus.o_state         = state_q;
    assign bus.o_is_gaming     = state_q == PLAY;
    assign bus.o_player_hp     = php_q;
    assign bus.o_enemy_hp      = ehp_q;
    assign bus.o_player_rounds = prnd_q;
    assign bus.o_enemy_rounds  = ernd_q;
    assign bus.o_player_invuln = pinv_q != '0;
    assign bus.o_enemy_invuln  = einv_q != '0;
    assign bus.o_round_start   = rs_q;
    assign bus.o_ai_tick       = tick_q;
endmodule
